acc_drain: RTL and testbench

- Sits at the output edge of the systolic PE array and terminates the per-row accumulator shift chains.
- Issues the one-cycle shift_acc command to the array.
- Captures the COLS accumulator words that then emerge back-to-back from each row's chain. The chain cannot stall, so all words are buffered first.
- Replays the full ROWS x COLS result tile, row-major, on a valid/ready stream.

---
 rtl/acc_drain_pkg.sv | 16 +
 rtl/acc_drain_row_buf.sv | 25 ++
 rtl/acc_drain.sv | 155 +++++++++++++++
 tb/tb_acc_drain.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/acc_drain_pkg.sv
// Shared types and constants for the accumulator drain.
// acc_drain.sv adds protocol checking when ACC_DRAIN_PROTO_CHECK_EN is defined.
package acc_drain_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    // PEs emit acc[ACC_FRAC_LSB +: DATA_W_DEF] of their wide fixed-point accumulator.
    localparam int unsigned ACC_FRAC_LSB = 16;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCollect,
        StDrain
    } acc_drain_state_e;

endpackage

// File: rtl/acc_drain_row_buf.sv
// One row of the drain buffer: COLS x DATA_W registers, indexed write, combinational read.
module acc_drain_row_buf #(
    parameter int unsigned COLS   = 4,
    parameter int unsigned DATA_W = 32,
    localparam int unsigned IDX_W = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [COLS];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/acc_drain.sv
// Terminates the PE accumulator chains: issues shift_acc, buffers one tile, replays it row-major.
// Define ACC_DRAIN_PROTO_CHECK_EN to enable the sticky chain-protocol error flag on err.
module acc_drain
    import acc_drain_pkg::*;
#(
    parameter int unsigned ROWS   = 4,
    parameter int unsigned COLS   = 4,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   shift_acc,
    input  logic [ROWS*DATA_W-1:0] acc_in,
    input  logic [ROWS-1:0]        acc_in_valid,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   err
);

    localparam int unsigned NWORDS = ROWS * COLS;
    localparam int unsigned KW     = $clog2(COLS + 1);
    localparam int unsigned IW     = $clog2(NWORDS + 1);
    localparam int unsigned CW     = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned RW     = (ROWS > 1) ? $clog2(ROWS) : 1;

    acc_drain_state_e  state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [IW-1:0]     i_q, i_d;
    logic              done_q, done_d;
    logic [ROWS-1:0]   wr_en;
    logic [CW-1:0]     wr_idx, rd_idx;
    logic [RW-1:0]     rd_row;
    logic [DATA_W-1:0] rd_data [ROWS];
    logic              last_word;

    assign last_word = (i_q == IW'(NWORDS - 1));
    // Chains deliver the PE nearest the drain first, so fill columns from the top down.
    assign wr_idx    = CW'(KW'(COLS - 1) - k_q);
    assign rd_idx    = CW'(i_q % IW'(COLS));
    assign rd_row    = RW'(i_q / IW'(COLS));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            k_q     <= '0;
            i_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            i_q     <= i_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        i_d     = i_q;
        done_d  = 1'b0;
        wr_en   = '0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                k_d     = '0;
                state_d = StCollect;
            end
            StCollect: begin
                if (acc_in_valid[0]) begin
                    wr_en = acc_in_valid;
                    k_d   = k_q + KW'(1);
                    if (k_q == KW'(COLS - 1)) begin
                        i_d     = '0;
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (out_ready) begin
                    if (last_word) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        i_d = i_q + IW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        acc_drain_row_buf #(
            .COLS   (COLS),
            .DATA_W (DATA_W)
        ) u_row_buf (
            .clock   (clock),
            .wr_en   (wr_en[r]),
            .wr_idx  (wr_idx),
            .wr_data (acc_in[r*DATA_W +: DATA_W]),
            .rd_idx  (rd_idx),
            .rd_data (rd_data[r])
        );
    end

    assign busy      = (state_q != StIdle);
    assign shift_acc = (state_q == StShift);
    assign out_valid = (state_q == StDrain);
    assign out_last  = out_valid && last_word;
    // Buffer is never reset, so mask the read path outside DRAIN.
    assign out_data  = out_valid ? rd_data[rd_row] : '0;
    assign done      = done_q;

`ifdef ACC_DRAIN_PROTO_CHECK_EN
    logic err_q;
    logic proto_err;

    always_comb begin
        proto_err = 1'b0;
        if (state_q == StCollect) begin
            if ((acc_in_valid != '0) && (acc_in_valid != '1)) begin
                proto_err = 1'b1;
            end
            // A gap once the first word has landed means the chain stalled.
            if (!acc_in_valid[0] && (k_q != '0)) begin
                proto_err = 1'b1;
            end
        end else if (acc_in_valid != '0) begin
            proto_err = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            err_q <= 1'b0;
        end else if (proto_err) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_acc_drain.sv
// Directed self-checking bench for acc_drain with ROWS=2, COLS=3.
module tb_acc_drain;

    localparam int ROWS = 2;
    localparam int COLS = 3;
    localparam int DW   = 32;
    localparam int N    = ROWS * COLS;
`ifdef ACC_DRAIN_PROTO_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic                 clock = 1'b0;
    logic                 resetn = 1'b0;
    logic                 start = 1'b0;
    logic                 busy, done, shift_acc;
    logic [ROWS*DW-1:0]   acc_in = '0;
    logic [ROWS-1:0]      acc_in_valid = '0;
    logic [DW-1:0]        out_data;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic                 out_last;
    logic                 err;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] exp_q  [N]    = '{32'h11, 32'h12, 32'h13, 32'h21, 32'h22, 32'h23};
    logic [DW-1:0] row0_w [COLS] = '{32'h13, 32'h12, 32'h11};
    logic [DW-1:0] row1_w [COLS] = '{32'h23, 32'h22, 32'h21};

    acc_drain #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .DATA_W (DW)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .shift_acc    (shift_acc),
        .acc_in       (acc_in),
        .acc_in_valid (acc_in_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .err          (err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset(input string tag);
        resetn       = 1'b0;
        start        = 1'b0;
        acc_in_valid = '0;
        out_ready    = 1'b0;
        #1;
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_shift"}, shift_acc, 1'b0);
        check({tag, "_valid"}, out_valid, 1'b0);
        check({tag, "_last"}, out_last, 1'b0);
        check({tag, "_data"}, out_data, '0);
        check({tag, "_err"}, err, 1'b0);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    // One tile: lat extra array cycles, pct = out_ready percentage, hold keeps start high.
    // abort_collect / abort_drain >= 0 reset after that many words written / accepted.
    task automatic do_tile(input int lat, input int pct, input bit hold,
                           input int abort_collect, input int abort_drain);
        int guard;
        int shifts;
        int got;
        int w;
        bit stalled;
        logic [DW-1:0] stall_data;
        start = 1'b1;
        guard = 0;
        while (!shift_acc && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        check("shift_seen", shift_acc, 1'b1);
        shifts = 1;
        if (!hold) start = 1'b0;
        for (int n = 1; n <= lat + COLS; n++) begin
            @(negedge clock);
            if (shift_acc) shifts++;
            check("collect_no_valid", out_valid, 1'b0);
            w = n - 1 - lat;
            if (abort_collect >= 0 && w == abort_collect) begin
                pulse_reset("rst_collect");
                return;
            end
            if (w >= 0) begin
                acc_in_valid = '1;
                acc_in       = {row1_w[w], row0_w[w]};
            end else begin
                acc_in_valid = '0;
            end
        end
        got     = 0;
        guard   = 0;
        stalled = 1'b0;
        while (got < N && guard < 400) begin
            @(negedge clock);
            guard++;
            acc_in_valid = '0;
            if (shift_acc) shifts++;
            if (stalled) begin
                check("stall_stable", out_data, stall_data);
                check("stall_valid", out_valid, 1'b1);
            end
            if (abort_drain >= 0 && got == abort_drain) begin
                pulse_reset("rst_drain");
                return;
            end
            out_ready = ($urandom_range(99) < pct);
            stalled   = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    check("out_data", out_data, exp_q[got]);
                    check("out_last", out_last, (got == N - 1));
                    got++;
                end else begin
                    stalled    = 1'b1;
                    stall_data = out_data;
                end
            end
        end
        check("drain_count", got, N);
        @(negedge clock);
        out_ready = 1'b0;
        check("done_pulse", done, 1'b1);
        check("done_busy", busy, 1'b0);
        check("done_no_valid", out_valid, 1'b0);
        @(negedge clock);
        if (hold) begin
            check("next_shift", shift_acc, 1'b1);
        end else begin
            check("done_cleared", done, 1'b0);
            check("idle_busy", busy, 1'b0);
        end
        check("one_shift", shifts, 1);
    endtask

    initial begin
        int guard;
        pulse_reset("reset");
        @(negedge clock);

        do_tile(1, 100, 1'b0, -1, -1);
        check("err_clean", err, 1'b0);
        do_tile(1, 30, 1'b0, -1, -1);
        do_tile(0, 100, 1'b0, -1, -1);
        do_tile(5, 100, 1'b0, -1, -1);
        do_tile(1, 100, 1'b1, -1, -1);
        do_tile(1, 100, 1'b0, -1, -1);
        do_tile(1, 100, 1'b0, 1, -1);
        do_tile(1, 100, 1'b0, -1, -1);
        do_tile(2, 100, 1'b0, -1, 2);
        do_tile(2, 30, 1'b0, -1, -1);
        check("err_clean_end", err, 1'b0);

        // Rows out of lockstep: only row 0 reports valid.
        start = 1'b1;
        guard = 0;
        while (!shift_acc && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        check("err_shift_seen", shift_acc, 1'b1);
        start = 1'b0;
        for (int n = 0; n < COLS; n++) begin
            @(negedge clock);
            acc_in_valid = 2'b01;
            acc_in       = {row1_w[n], row0_w[n]};
        end
        @(negedge clock);
        acc_in_valid = '0;
        check("err_set", err, ERR_EN);
        out_ready = 1'b1;
        guard = 0;
        while (!done && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        out_ready = 1'b0;
        check("err_done", done, 1'b1);
        check("err_sticky", err, ERR_EN);
        @(negedge clock);
        check("err_sticky_idle", err, ERR_EN);
        pulse_reset("err_reset");
        @(negedge clock);
        check("err_after_reset", err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
